// File: rtl/alu_pkg.sv
// alu_pkg: op codes, slice selects and FSM states shared by alu_serial and its slice
package alu_pkg;
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_LESS = 2'b11;
endpackage

// File: rtl/alu_serial_if.sv
// alu_serial_if: operand/result handshake bundle for alu_serial
//   master: drives in_valid, a, b, op, out_ready; sees in_ready, out_valid, result, zero, carry_out, ovf
//   slave : the ALU side of the same signals
interface alu_serial_if #(parameter int WIDTH = 32);
    logic             in_valid, in_ready, out_valid, out_ready;
    logic             zero, carry_out, ovf;
    logic [WIDTH-1:0] a, b, result;
    logic [2:0]       op;
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry_out, ovf
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry_out, ovf
    );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: CHUNK-bit combinational and/or/add slice with chained carry
//   a, bm : operand chunk and (possibly inverted) B chunk
//   cin   : carry into the chunk; sel : 00 and, 01 or, 10 sum, 11 zeros (less handled by caller)
//   y     : selected chunk result; cout : carry out; cmsb : carry into chunk MSB; smsb : sum MSB
module alu_slice import alu_pkg::*; #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] bm,
    input  logic             cin,
    input  logic [1:0]       sel,
    output logic [CHUNK-1:0] y,
    output logic             cout,
    output logic             cmsb,
    output logic             smsb
);
    logic [CHUNK-1:0] sum;
    assign {cout, sum} = {1'b0, a} + {1'b0, bm} + {{CHUNK{1'b0}}, cin};
    // carry into the MSB recovered from the MSB sum bit, valid for any CHUNK
    assign cmsb = a[CHUNK-1] ^ bm[CHUNK-1] ^ sum[CHUNK-1];
    assign smsb = sum[CHUNK-1];
    assign y = sel == SEL_AND ? a & bm : sel == SEL_OR ? a | bm : sel == SEL_ADD ? sum : '0;
endmodule

// File: rtl/alu_serial.sv
// alu_serial: chunk-serial ALU (and/or/add/sub/slt), one CHUNK per cycle, LSB chunk first
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_serial_if.slave (in_valid/in_ready, a, b, op, out_valid/out_ready, result, zero, carry_out, ovf)
//   ALU_SERIAL_OVF_EN : enables signed overflow flag and signed SLT; otherwise ovf is 0 and SLT uses the sum MSB
module alu_serial import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic clk,
    input logic rst,
    alu_serial_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, bm_r, res_r, res_n;
    logic [1:0]       sel;
    logic             c_r, zero_r, cout_r, last, cout, smsb, set;
    logic [CHUNK-1:0] y;
`ifdef ALU_SERIAL_OVF_EN
    logic cmsb, ovf_n, ovf_r;
`else
    logic unused_cmsb;
`endif
    assign last = cnt == CW'(NCH - 1);
    alu_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_r[int'(cnt)*CHUNK +: CHUNK]),
        .bm   (bm_r[int'(cnt)*CHUNK +: CHUNK]),
        .cin  (c_r),
        .sel  (sel),
        .y    (y),
        .cout (cout),
`ifdef ALU_SERIAL_OVF_EN
        .cmsb (cmsb),
`else
        .cmsb (unused_cmsb),
`endif
        .smsb (smsb)
    );
`ifdef ALU_SERIAL_OVF_EN
    assign ovf_n = cmsb ^ cout;
    assign set = smsb ^ ovf_n;
    assign bus.ovf = ovf_r;
    always_ff @(posedge clk)
        if (rst) ovf_r <= 1'b0;
        else if (state == S_BUSY && last) ovf_r <= ovf_n;
`else
    assign set = smsb;
    assign bus.ovf = 1'b0;
`endif
    // less op: all chunks write zeros, bit 0 takes the set flag on the final chunk
    always_comb begin
        res_n = res_r;
        res_n[int'(cnt)*CHUNK +: CHUNK] = y;
        if (last && sel == SEL_LESS) res_n[0] = set;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            c_r    <= 1'b0;
            a_r    <= '0;
            bm_r   <= '0;
            sel    <= '0;
            res_r  <= '0;
            zero_r <= 1'b0;
            cout_r <= 1'b0;
        end else if (state == S_IDLE) begin
            if (bus.in_valid) begin
                state <= S_BUSY;
                cnt   <= '0;
                a_r   <= bus.a;
                bm_r  <= bus.op[2] ? ~bus.b : bus.b;
                sel   <= bus.op[1:0];
                c_r   <= bus.op[2];
            end
        end else if (state == S_BUSY) begin
            res_r <= res_n;
            c_r   <= cout;
            cnt   <= last ? cnt : cnt + 1'b1;
            if (last) begin
                state  <= S_DONE;
                zero_r <= res_n == '0;
                cout_r <= cout;
            end
        end else if (bus.out_ready) begin
            state <= S_IDLE;
        end
    end
    assign bus.in_ready  = (state == S_IDLE) & ~rst;
    assign bus.out_valid = state == S_DONE;
    assign bus.result    = res_r;
    assign bus.zero      = zero_r;
    assign bus.carry_out = cout_r;
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: scoreboard bench for alu_serial (WIDTH=32, CHUNK=8), honours ALU_SERIAL_OVF_EN
module tb_alu_serial;
    import alu_pkg::*;
    typedef struct {
        logic [31:0] res;
        logic        z, c, v;
        int          acc;
        string       name;
    } exp_t;
`ifdef ALU_SERIAL_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    logic pv = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e;

    alu_serial_if #(.WIDTH(32)) bus();
    alu_serial #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: checks latency on out_valid rise, scores the result on each handshake
    always @(negedge clk) begin
        if (!rst && bus.out_valid && !pv) begin
            chk("out_valid_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) chk({q[0].name, "_latency"}, 32'(cyc - q[0].acc), 4);
        end
        if (!rst && bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, "_result"}, bus.result, e.res);
            chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
            chk({e.name, "_carry"}, 32'(bus.carry_out), 32'(e.c));
            chk({e.name, "_ovf"}, 32'(bus.ovf), 32'(e.v));
        end
        pv = bus.out_valid;
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a, b, res,
                         input logic z, c, v);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        q.push_back('{res: res, z: z, c: c, v: v, acc: cyc, name: name});
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        chk({name, "_completed"}, 32'(q.size()), 0);
        q.delete();
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, b, res,
                       input logic z, c, v);
        issue(name, op, a, b, res, z, c, v);
        wait_done(name);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({name, "_result"}, bus.result, 0);
        chk({name, "_zero"}, 32'(bus.zero), 0);
        chk({name, "_carry"}, 32'(bus.carry_out), 0);
        chk({name, "_ovf"}, 32'(bus.ovf), 0);
        chk({name, "_in_ready"}, 32'(bus.in_ready), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;
        #1 chk("reset_release_in_ready", 32'(bus.in_ready), 1);

        run("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        run("sub_ovf",  OP_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, OVF);
        run("slt_neg",  OP_SLT, 32'h80000000, 32'h00000001, 32'(OVF), ~OVF, 1'b1, OVF);
        run("and_inv",  3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
        run("or",       OP_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0);
        run("and_zero", OP_AND, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, OVF);
        run("slt_3_5",  OP_SLT, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0);

        bus.out_ready = 1'b0;
        issue("stall_sub", OP_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, OVF);
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(bus.out_valid), 1);
            chk("stall_result", bus.result, 32'h80000000);
            chk("stall_zero", 32'(bus.zero), 0);
            chk("stall_carry", 32'(bus.carry_out), 0);
            chk("stall_ovf", 32'(bus.ovf), 32'(OVF));
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            bus.in_valid = i[0];
            bus.op = OP_ADD;
            bus.a = 32'h00001234;
            bus.b = 32'h00004321;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_done("stall_sub");
        run("after_stall", OP_SLT, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        chk("midrst_in_ready_before", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.a = 32'h11111111;
        bus.b = 32'h22222222;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_cleared("midrst");
        rst = 1'b0;
        #1 chk("midrst_release_in_ready", 32'(bus.in_ready), 1);
        run("add_after_rst", OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
